alu_issue: RTL and testbench
============================

# alu_issue

Issue/operand stage directly upstream of the 8-bit `ALU`: accepts 9-bit ALU instructions over a valid/ready handshake, reads operands from an internal 8×8 register file, and drives the ALU's `in1`/`in2`/`alu_op`/`sub` from registers. It captures the ALU's `out_val` on the following clock edge and writes it back to the destination register. An external load port preloads registers, and a retire counter tracks completed instructions.

## Interface
- `DW`, 8: datapath width; must match the ALU.
- `CNT_W`, 16: retire counter width.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `instr_valid`  in  1  instruction offered.
- `instr`  in  9  [8:7] alu_op, [6] sub, [5:3] rd (also first source), [2:0] rs2.
- `instr_ready`  out  1  instruction accepted when valid && ready.
- `ld_valid`  in  1  external register-file write request.
- `ld_addr`  in  3  load destination.
- `ld_data`  in  DW  load value.
- `ld_ready`  out  1  load accepted when valid && ready.
- `alu_in1`, `alu_in2`  out  DW  registered operands to the ALU.
- `alu_op`  out  2  registered op to the ALU.
- `alu_sub`  out  1  registered sub/direction to the ALU.
- `alu_out_val`  in  DW  combinational ALU result.
- `ex_valid`  out  1  the ALU currently holds a live instruction.
- `dbg_addr`  in  3  debug read address.
- `dbg_data`  out  DW  RF[dbg_addr], combinational; pre-write value on a same-cycle write.
- `retire_cnt`  out  CNT_W  completed writebacks.

## Operation
- Two stages.
  - ISSUE: on accept, at the clock edge, `alu_in1` ← RF[rd], `alu_in2` ← RF[rs2], `alu_op`/`alu_sub` ← instr fields, `ex_rd` ← rd, `ex_valid` ← 1.
  - EX: while `ex_valid`, at the next edge, RF[`ex_rd`] ← `alu_out_val` and `retire_cnt` increments.
- `ex_valid` clears on any edge with no accept.
- ALU outputs hold their last values when idle; they are not zeroed.
- Arithmetic is entirely in the ALU; this block never modifies the data. The result is truncated to DW by the ALU.
- Hazard: an instruction in ISSUE whose rd or rs2 equals `ex_rd` while `ex_valid` is a RAW hazard; handling is set by the macro (see Configuration).
- Load port:
  - `ld_ready` = !`ex_valid`.
  - An accepted load writes RF[`ld_addr`] ← `ld_data` at the edge.
  - When a load is accepted, `instr_ready` = 0 in that cycle: loads have priority over instructions.
- `instr_ready` = !reset && !(`ld_valid` && `ld_ready`) && !stall.
- `retire_cnt` wraps from 2^CNT_W−1 to 0.
- All 8 registers are writable; there is no hardwired zero.

## Timing
- Reset values, applied immediately: RF all 0; `alu_in1`, `alu_in2`, `alu_op`, `alu_sub` = 0; `ex_valid` = 0; `retire_cnt` = 0.
- While reset is asserted: `instr_ready` = 0 and `ld_ready` = 0.
- Latency: accept in cycle N → ALU inputs valid in cycle N+1 → RF updated and visible on `dbg_data` in cycle N+2.
- Throughput: one instruction per cycle.
- Reset during `ex_valid`: the in-flight instruction is discarded with no writeback and no count.
- A debug read of `ex_rd` in the writeback cycle returns the old value.

## Configuration
- `ALU_ISSUE_FWD_EN` defined:
  - A hazarding source operand takes `alu_out_val` instead of the RF value.
  - No stalls; back-to-back dependent instructions run at full rate.
- Not defined:
  - On a hazard, `instr_ready` = 0 for exactly one cycle (stall).
  - The instruction issues the next cycle, reading the freshly written RF.

## Structure
- Package `alu_pkg`:
  - `alu_op_e` enum: ADD=2'b00, ANDB=2'b01, XOR=2'b10, SHFT=2'b11.
  - Instr field bit-position constants, `NUM_REGS`=8, `DW` default.
- Sub-module `alu_regfile`:
  - 8×DW, async reset.
  - Read ports: rd, rs2, dbg (combinational).
  - One write port, muxed between EX writeback and load; they are mutually exclusive by construction.

## Test plan
- Reset → `dbg_data` = 0 for all 8 addresses; `retire_cnt` = 0; ALU outputs 0; `instr_ready` = 1 after deassert.
- Load r1=10, r2=15; issue ADD rd=1, rs2=2 → next cycle `alu_in1`=10, `alu_in2`=15, `ex_valid`=1; following cycle RF[1]=25, `retire_cnt`=1.
- Load r1=20, r2=5; two back-to-back SUB rd=1, rs2=2 → with FWD_EN: second `alu_in1`=15, final r1=10, no stall; without: `instr_ready` low exactly one cycle, same final value.
- Load r3=3, r4=2; SHFT sub=0 rd=3, rs2=4 → r3=12; then SHFT sub=1 rd=3, rs2=4 → r3=3.
- `ld_valid` with `ex_valid`=1 → `ld_ready`=0; load lands the cycle after EX drains. `ld_valid` and `instr_valid` together while idle → load taken, `instr_ready`=0.
- Assert reset while `ex_valid`=1 with pending r5 writeback → r5 stays 0 and `retire_cnt`=0. Preset counter at 0xFFFF plus one retire → wraps to 0x0000.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared types and constants for the ALU issue stage and its register file.
package alu_pkg;

    typedef enum logic [1:0] {
        ADD  = 2'b00,
        ANDB = 2'b01,
        XOR  = 2'b10,
        SHFT = 2'b11
    } alu_op_e;

    localparam int unsigned DEFAULT_DW = 8;
    localparam int unsigned NUM_REGS   = 8;
    localparam int unsigned REG_AW     = 3;
    localparam int unsigned INSTR_W    = 9;

    localparam int unsigned OP_MSB  = 8;
    localparam int unsigned OP_LSB  = 7;
    localparam int unsigned SUB_BIT = 6;
    localparam int unsigned RD_MSB  = 5;
    localparam int unsigned RD_LSB  = 3;
    localparam int unsigned RS2_MSB = 2;
    localparam int unsigned RS2_LSB = 0;

endpackage

// File: rtl/alu_issue_if.sv
// Instruction and register-load handshakes feeding the ALU issue stage.
interface alu_issue_if #(
    parameter int DW = 8
) ();
    logic       instr_valid;
    logic [8:0] instr;
    logic       instr_ready;
    logic       ld_valid;
    logic [2:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic       ld_ready;

    modport master (
        output instr_valid, instr, ld_valid, ld_addr, ld_data,
        input  instr_ready, ld_ready
    );

    modport slave (
        input  instr_valid, instr, ld_valid, ld_addr, ld_data,
        output instr_ready, ld_ready
    );
endinterface

// File: rtl/alu_issue_regfile.sv
// 8 x DW register file: three combinational read ports, one write port, async reset.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int DW = DEFAULT_DW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rd_addr_i,
    input  logic [REG_AW-1:0] rs2_addr_i,
    input  logic [REG_AW-1:0] dbg_addr_i,
    output logic [DW-1:0]     rd_data_o,
    output logic [DW-1:0]     rs2_data_o,
    output logic [DW-1:0]     dbg_data_o,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [DW-1:0]     wdata_i
);

    logic [DW-1:0] regs_q [NUM_REGS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rd_data_o  = regs_q[rd_addr_i];
    assign rs2_data_o = regs_q[rs2_addr_i];
    assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue.sv
// Issue/operand stage in front of the 8-bit ALU with writeback and retire count.
// ALU_ISSUE_FWD_EN: forward alu_out_val to hazarding operands instead of stalling.
module alu_issue
    import alu_pkg::*;
#(
    parameter int DW    = DEFAULT_DW,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    alu_issue_if.slave       bus,
    output logic [DW-1:0]    alu_in1,
    output logic [DW-1:0]    alu_in2,
    output logic [1:0]       alu_op,
    output logic             alu_sub,
    input  logic [DW-1:0]    alu_out_val,
    output logic             ex_valid,
    input  logic [2:0]       dbg_addr,
    output logic [DW-1:0]    dbg_data,
    output logic [CNT_W-1:0] retire_cnt
);

    logic [DW-1:0]     alu_in1_q, alu_in1_d;
    logic [DW-1:0]     alu_in2_q, alu_in2_d;
    alu_op_e           alu_op_q, alu_op_d;
    logic              alu_sub_q, alu_sub_d;
    logic              ex_valid_q, ex_valid_d;
    logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
    logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;

    logic [REG_AW-1:0] rd_f, rs2_f;
    alu_op_e           op_f;
    logic              sub_f;
    logic [DW-1:0]     rf_rd, rf_rs2, op1, op2;
    logic              haz1, haz2, stall, accept, ld_accept;
    logic              we;
    logic [REG_AW-1:0] waddr;
    logic [DW-1:0]     wdata;

    assign rd_f  = bus.instr[RD_MSB:RD_LSB];
    assign rs2_f = bus.instr[RS2_MSB:RS2_LSB];
    assign op_f  = alu_op_e'(bus.instr[OP_MSB:OP_LSB]);
    assign sub_f = bus.instr[SUB_BIT];

    assign haz1 = ex_valid_q && (rd_f == ex_rd_q);
    assign haz2 = ex_valid_q && (rs2_f == ex_rd_q);

`ifdef ALU_ISSUE_FWD_EN
    assign stall = 1'b0;
    assign op1   = haz1 ? alu_out_val : rf_rd;
    assign op2   = haz2 ? alu_out_val : rf_rs2;
`else
    // Hold the dependent instruction one cycle so it reads the written-back RF.
    assign stall = bus.instr_valid && (haz1 || haz2);
    assign op1   = rf_rd;
    assign op2   = rf_rs2;
`endif

    assign bus.ld_ready    = !reset && !ex_valid_q;
    assign ld_accept       = bus.ld_valid && bus.ld_ready;
    assign bus.instr_ready = !reset && !ld_accept && !stall;
    assign accept          = bus.instr_valid && bus.instr_ready;

    // Writeback and load never coincide: loads are only accepted with EX empty.
    always_comb begin
        we    = 1'b0;
        waddr = '0;
        wdata = '0;
        if (ex_valid_q) begin
            we    = 1'b1;
            waddr = ex_rd_q;
            wdata = alu_out_val;
        end else if (ld_accept) begin
            we    = 1'b1;
            waddr = bus.ld_addr;
            wdata = bus.ld_data;
        end
    end

    always_comb begin
        alu_in1_d    = alu_in1_q;
        alu_in2_d    = alu_in2_q;
        alu_op_d     = alu_op_q;
        alu_sub_d    = alu_sub_q;
        ex_rd_d      = ex_rd_q;
        ex_valid_d   = accept;
        retire_cnt_d = retire_cnt_q + CNT_W'(ex_valid_q);
        if (accept) begin
            alu_in1_d = op1;
            alu_in2_d = op2;
            alu_op_d  = op_f;
            alu_sub_d = sub_f;
            ex_rd_d   = rd_f;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_in1_q    <= '0;
            alu_in2_q    <= '0;
            alu_op_q     <= ADD;
            alu_sub_q    <= 1'b0;
            ex_valid_q   <= 1'b0;
            ex_rd_q      <= '0;
            retire_cnt_q <= '0;
        end else begin
            alu_in1_q    <= alu_in1_d;
            alu_in2_q    <= alu_in2_d;
            alu_op_q     <= alu_op_d;
            alu_sub_q    <= alu_sub_d;
            ex_valid_q   <= ex_valid_d;
            ex_rd_q      <= ex_rd_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    alu_regfile #(.DW(DW)) u_rf (
        .clk        (clk),
        .reset      (reset),
        .rd_addr_i  (rd_f),
        .rs2_addr_i (rs2_f),
        .dbg_addr_i (dbg_addr),
        .rd_data_o  (rf_rd),
        .rs2_data_o (rf_rs2),
        .dbg_data_o (dbg_data),
        .we_i       (we),
        .waddr_i    (waddr),
        .wdata_i    (wdata)
    );

    assign alu_in1    = alu_in1_q;
    assign alu_in2    = alu_in2_q;
    assign alu_op     = alu_op_q;
    assign alu_sub    = alu_sub_q;
    assign ex_valid   = ex_valid_q;
    assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed self-checking bench for alu_issue with a behavioural 8-bit ALU model.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  alu_in1, alu_in2, alu_out_val, dbg_data;
    logic [1:0]  alu_op;
    logic        alu_sub, ex_valid;
    logic [2:0]  dbg_addr;
    logic [15:0] retire_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    alu_issue_if #(.DW(8)) bus_if ();

    alu_issue #(.DW(8), .CNT_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus_if),
        .alu_in1     (alu_in1),
        .alu_in2     (alu_in2),
        .alu_op      (alu_op),
        .alu_sub     (alu_sub),
        .alu_out_val (alu_out_val),
        .ex_valid    (ex_valid),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data),
        .retire_cnt  (retire_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [1:0] op, input logic sub,
                                         input logic [7:0] a, input logic [7:0] b);
        case (op)
            2'b00:   alu_f = sub ? (a - b) : (a + b);
            2'b01:   alu_f = a & b;
            2'b10:   alu_f = a ^ b;
            default: alu_f = sub ? (a >> b) : (a << b);
        endcase
    endfunction

    always_comb alu_out_val = alu_f(alu_op, alu_sub, alu_in1, alu_in2);

    function automatic logic [8:0] mk(input logic [1:0] op, input logic sub,
                                      input logic [2:0] rd, input logic [2:0] rs2);
        mk = {op, sub, rd, rs2};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [7:0] exp);
        dbg_addr = a;
        #1;
        chk(tag, {24'd0, dbg_data}, {24'd0, exp});
    endtask

    task automatic load(input logic [2:0] a, input logic [7:0] d);
        bus_if.ld_valid = 1'b1;
        bus_if.ld_addr  = a;
        bus_if.ld_data  = d;
        tick();
        bus_if.ld_valid = 1'b0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus_if.instr_valid = 1'b0;
        bus_if.instr       = '0;
        bus_if.ld_valid    = 1'b0;
        bus_if.ld_addr     = '0;
        bus_if.ld_data     = '0;
        dbg_addr           = '0;
        reset              = 1'b0;
        #1 reset = 1'b1;
        #2;

        // Reset state
        chk("rst_instr_ready", {31'd0, bus_if.instr_ready}, 32'd0);
        chk("rst_ld_ready", {31'd0, bus_if.ld_ready}, 32'd0);
        chk("rst_retire", {16'd0, retire_cnt}, 32'd0);
        chk("rst_alu_in1", {24'd0, alu_in1}, 32'd0);
        chk("rst_alu_in2", {24'd0, alu_in2}, 32'd0);
        chk("rst_alu_op", {30'd0, alu_op}, 32'd0);
        chk("rst_alu_sub", {31'd0, alu_sub}, 32'd0);
        chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        for (int i = 0; i < 8; i++) rd_chk("rst_rf", 3'(i), 8'd0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("post_rst_instr_ready", {31'd0, bus_if.instr_ready}, 32'd1);
        chk("post_rst_ld_ready", {31'd0, bus_if.ld_ready}, 32'd1);

        // Basic ADD: r1=10 + r2=15
        load(3'd1, 8'd10);
        load(3'd2, 8'd15);
        bus_if.instr_valid = 1'b1;
        bus_if.instr = mk(2'b00, 1'b0, 3'd1, 3'd2);
        #1;
        chk("add_ready", {31'd0, bus_if.instr_ready}, 32'd1);
        tick();
        bus_if.instr_valid = 1'b0;
        chk("add_in1", {24'd0, alu_in1}, 32'd10);
        chk("add_in2", {24'd0, alu_in2}, 32'd15);
        chk("add_ex_valid", {31'd0, ex_valid}, 32'd1);
        rd_chk("add_wb_cycle_old", 3'd1, 8'd10);
        tick();
        rd_chk("add_result", 3'd1, 8'd25);
        chk("add_retire", {16'd0, retire_cnt}, 32'd1);
        chk("add_ex_clear", {31'd0, ex_valid}, 32'd0);
        chk("add_in1_hold", {24'd0, alu_in1}, 32'd10);

        // Back-to-back dependent SUBs: 20-5-5
        load(3'd1, 8'd20);
        load(3'd2, 8'd5);
        bus_if.instr_valid = 1'b1;
        bus_if.instr = mk(2'b00, 1'b1, 3'd1, 3'd2);
        #1;
        chk("sub1_ready", {31'd0, bus_if.instr_ready}, 32'd1);
        tick();
        chk("sub1_in1", {24'd0, alu_in1}, 32'd20);
        chk("sub1_in2", {24'd0, alu_in2}, 32'd5);
`ifdef ALU_ISSUE_FWD_EN
        chk("sub2_ready_fwd", {31'd0, bus_if.instr_ready}, 32'd1);
        tick();
        bus_if.instr_valid = 1'b0;
        chk("sub2_in1_fwd", {24'd0, alu_in1}, 32'd15);
        chk("sub2_in2_fwd", {24'd0, alu_in2}, 32'd5);
        tick();
`else
        chk("sub2_stall", {31'd0, bus_if.instr_ready}, 32'd0);
        tick();
        chk("sub2_ready_after", {31'd0, bus_if.instr_ready}, 32'd1);
        rd_chk("sub1_result", 3'd1, 8'd15);
        tick();
        bus_if.instr_valid = 1'b0;
        chk("sub2_in1", {24'd0, alu_in1}, 32'd15);
        tick();
`endif
        rd_chk("sub_final", 3'd1, 8'd10);
        chk("sub_retire", {16'd0, retire_cnt}, 32'd3);

        // Shifts: 3<<2 then 12>>2
        load(3'd3, 8'd3);
        load(3'd4, 8'd2);
        bus_if.instr_valid = 1'b1;
        bus_if.instr = mk(2'b11, 1'b0, 3'd3, 3'd4);
        tick();
        bus_if.instr_valid = 1'b0;
        chk("shl_op", {30'd0, alu_op}, 32'd3);
        tick();
        rd_chk("shl_result", 3'd3, 8'd12);
        bus_if.instr_valid = 1'b1;
        bus_if.instr = mk(2'b11, 1'b1, 3'd3, 3'd4);
        tick();
        bus_if.instr_valid = 1'b0;
        chk("shr_sub", {31'd0, alu_sub}, 32'd1);
        tick();
        rd_chk("shr_result", 3'd3, 8'd3);
        chk("shift_retire", {16'd0, retire_cnt}, 32'd5);

        // Load blocked while EX busy, lands after drain
        bus_if.instr_valid = 1'b1;
        bus_if.instr = mk(2'b00, 1'b0, 3'd0, 3'd0);
        tick();
        bus_if.instr_valid = 1'b0;
        bus_if.ld_valid = 1'b1;
        bus_if.ld_addr  = 3'd6;
        bus_if.ld_data  = 8'h77;
        #1;
        chk("ld_blocked", {31'd0, bus_if.ld_ready}, 32'd0);
        tick();
        chk("ld_ready_drained", {31'd0, bus_if.ld_ready}, 32'd1);
        tick();
        bus_if.ld_valid = 1'b0;
        rd_chk("ld_landed", 3'd6, 8'h77);

        // Load and instruction together: load wins
        bus_if.ld_valid = 1'b1;
        bus_if.ld_addr  = 3'd7;
        bus_if.ld_data  = 8'h5A;
        bus_if.instr_valid = 1'b1;
        bus_if.instr = mk(2'b00, 1'b0, 3'd7, 3'd7);
        #1;
        chk("prio_ld_ready", {31'd0, bus_if.ld_ready}, 32'd1);
        chk("prio_instr_ready", {31'd0, bus_if.instr_ready}, 32'd0);
        tick();
        bus_if.ld_valid = 1'b0;
        chk("prio_no_issue", {31'd0, ex_valid}, 32'd0);
        rd_chk("prio_ld_data", 3'd7, 8'h5A);
        chk("prio_instr_now", {31'd0, bus_if.instr_ready}, 32'd1);
        tick();
        bus_if.instr_valid = 1'b0;
        chk("prio_in1", {24'd0, alu_in1}, 32'h5A);
        tick();
        rd_chk("prio_result", 3'd7, 8'hB4);
        chk("prio_retire", {16'd0, retire_cnt}, 32'd7);

        // Reset with r5 writeback in flight
        bus_if.instr_valid = 1'b1;
        bus_if.instr = mk(2'b00, 1'b0, 3'd5, 3'd1);
        tick();
        bus_if.instr_valid = 1'b0;
        chk("inflight_ex", {31'd0, ex_valid}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_fly_ex", {31'd0, ex_valid}, 32'd0);
        chk("rst_fly_retire", {16'd0, retire_cnt}, 32'd0);
        chk("rst_fly_ld_ready", {31'd0, bus_if.ld_ready}, 32'd0);
        tick();
        rd_chk("rst_fly_r5", 3'd5, 8'd0);
        chk("rst_fly_retire2", {16'd0, retire_cnt}, 32'd0);
        reset = 1'b0;
        tick();

        // Counter wrap: 65535 independent retires, then one more
        bus_if.instr_valid = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            bus_if.instr = (i % 2 == 0) ? mk(2'b00, 1'b0, 3'd0, 3'd1)
                                        : mk(2'b00, 1'b0, 3'd2, 3'd3);
            tick();
        end
        bus_if.instr_valid = 1'b0;
        tick();
        chk("cnt_max", {16'd0, retire_cnt}, 32'hFFFF);
        bus_if.instr_valid = 1'b1;
        bus_if.instr = mk(2'b01, 1'b0, 3'd4, 3'd5);
        tick();
        bus_if.instr_valid = 1'b0;
        tick();
        chk("cnt_wrap", {16'd0, retire_cnt}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
